// File: rtl/serial_tx_sequencer.sv
// serial_tx_sequencer: Avalon-MM slave framing one guarded serial byte per TXDATA write (clk, reset_n, address/chipselect/write_n/writedata/readdata bus; trans_en, tx_serial, irq out)
module serial_tx_sequencer #(
  parameter int DATA_BITS   = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 434,
  parameter int GUARD_BITS  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        trans_en,
  output logic        tx_serial,
  output logic        irq
);
  localparam int BW = $clog2(DATA_BITS > GUARD_BITS ? DATA_BITS : GUARD_BITS) + 1;
  typedef enum logic [2:0] {IDLE, LEAD, START, DATA, STOP, TRAIL} state_t;
  state_t state, next_state;
  logic ctrl_en, ctrl_ie, done_flag, overrun_flag;
  logic [DIV_WIDTH-1:0] div, shadow_div, cnt;
  logic [DATA_BITS-1:0] txdata, shift, shift_d;
  logic [BW-1:0] bcnt, bload;
  logic trans_en_d, tx_d;
  logic wr, wr_tx, wr_ctrl, wr_stat, wr_div, busy, accept, abort, tick, last;
  logic unused_bits;
  assign unused_bits = &{1'b0, writedata};
  assign wr      = chipselect & ~write_n;
  assign wr_tx   = wr & (address == 2'd0);
  assign wr_ctrl = wr & (address == 2'd1);
  assign wr_stat = wr & (address == 2'd2);
  assign wr_div  = wr & (address == 2'd3);
  assign busy    = state != IDLE;
  assign accept  = wr_tx & ctrl_en & ~busy;
  assign abort   = wr_ctrl & ~writedata[0] & busy;
  assign tick    = cnt == '0;
  assign last    = busy & tick & (bcnt == '0);
  assign irq     = done_flag & ctrl_ie;
  assign readdata = address == 2'd0 ? 32'(txdata) :
                    address == 2'd1 ? {30'd0, ctrl_ie, ctrl_en} :
                    address == 2'd2 ? {29'd0, overrun_flag, done_flag, busy} :
                                      32'(div);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (abort) next_state = IDLE;
    else if (accept) next_state = LEAD;
    else if (last)
      case (state)
        LEAD:    next_state = START;
        START:   next_state = DATA;
        DATA:    next_state = STOP;
        STOP:    next_state = TRAIL;
        default: next_state = IDLE;
      endcase
  end
  // Outputs are computed from the next state and registered, so the line only moves on period boundaries.
  always_comb begin
    shift_d    = accept ? writedata[DATA_BITS-1:0] :
                 (busy & tick & state == DATA) ? shift >> 1 : shift;
    bload      = next_state == DATA ? BW'(DATA_BITS - 1) :
                 (next_state == LEAD || next_state == TRAIL) ? BW'(GUARD_BITS - 1) : '0;
    trans_en_d = next_state != IDLE;
    tx_d       = next_state == START ? 1'b0 : next_state == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      trans_en     <= 1'b0;
      tx_serial    <= 1'b1;
      ctrl_en      <= 1'b0;
      ctrl_ie      <= 1'b0;
      done_flag    <= 1'b0;
      overrun_flag <= 1'b0;
      div          <= DIV_WIDTH'(DEFAULT_DIV);
      shadow_div   <= DIV_WIDTH'(DEFAULT_DIV);
      cnt          <= '0;
      bcnt         <= '0;
      txdata       <= '0;
      shift        <= '0;
    end else begin
      trans_en     <= trans_en_d;
      tx_serial    <= tx_d;
      shift        <= shift_d;
      if (wr_ctrl) {ctrl_ie, ctrl_en} <= writedata[1:0];
      if (wr_div) div <= writedata[DIV_WIDTH-1:0];
      // A set in the same cycle as a W1C clear wins.
      done_flag    <= (last & state == TRAIL & ~abort) | (done_flag & ~(wr_stat & writedata[1]));
      overrun_flag <= (wr_tx & ctrl_en & busy) | (overrun_flag & ~(wr_stat & writedata[2]));
      if (accept) begin
        txdata     <= writedata[DATA_BITS-1:0];
        shadow_div <= div;
        cnt        <= div;
        bcnt       <= BW'(GUARD_BITS - 1);
      end else if (busy) begin
        cnt  <= tick ? shadow_div : cnt - 1'b1;
        bcnt <= !tick ? bcnt : last ? bload : bcnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_serial_tx_sequencer.sv
// tb_serial_tx_sequencer: directed checks of framing, overrun, disable, divisor and abort behaviour
module tb_serial_tx_sequencer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] address = '0;
  logic chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0, readdata;
  logic trans_en, tx_serial, irq;
  int errors = 0, checks = 0;
  logic [31:0] v;
  logic [127:0] tx_v, en_v, tx_e, en_e;

  serial_tx_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .trans_en(trans_en), .tx_serial(tx_serial), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
  endtask

  task automatic capture(input int n, output logic [127:0] t, output logic [127:0] e);
    t = '1; e = '0;
    for (int i = 0; i < n; i++) begin
      t[i] = tx_serial; e[i] = trans_en;
      @(negedge clk);
    end
  endtask

  // Expected line per clock: lead high, start low, 8 data bits LSB first, stop and trail high.
  task automatic expect_frame(input logic [7:0] d, input int dv, input int n,
                              output logic [127:0] t, output logic [127:0] e);
    t = '1; e = '0;
    for (int i = 0; i < n; i++) begin
      int p;
      p = i / (dv + 1);
      e[i] = p < 12;
      t[i] = p == 1 ? 1'b0 : (p >= 2 && p <= 9) ? d[p-2] : 1'b1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(2'd1, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_ctrl got=%h want=%h", v, 32'd0); end
    rd(2'd2, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_status got=%h want=%h", v, 32'd0); end
    rd(2'd3, v); checks++;
    if (v !== 32'd434) begin errors++; $display("FAIL reset_div got=%0d want=434", v); end
    rd(2'd0, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_txdata got=%h want=0", v); end
    checks++;
    if ({trans_en, tx_serial, irq} !== 3'b010) begin
      errors++; $display("FAIL reset_pins got=%b want=010", {trans_en, tx_serial, irq});
    end
  endtask

  task automatic test_frame;
    wr(2'd1, 32'd3);
    wr(2'd3, 32'd3);
    wr(2'd0, 32'hA5);
    capture(50, tx_v, en_v);
    expect_frame(8'hA5, 3, 50, tx_e, en_e);
    checks++;
    if (tx_v !== tx_e) begin errors++; $display("FAIL frame_tx got=%h want=%h", tx_v, tx_e); end
    checks++;
    if (en_v !== en_e) begin errors++; $display("FAIL frame_en got=%h want=%h", en_v, en_e); end
    rd(2'd2, v); checks++;
    if (v !== 32'd2) begin errors++; $display("FAIL frame_done got=%h want=2", v); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL frame_irq got=%b want=1", irq); end
    wr(2'd2, 32'd2);
    rd(2'd2, v); checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL done_clear got=%h irq=%b want=0", v, irq); end
  endtask

  task automatic test_overrun;
    wr(2'd0, 32'h5A);
    fork
      capture(50, tx_v, en_v);
      begin repeat (9) @(negedge clk); wr(2'd0, 32'h3C); end
    join
    expect_frame(8'h5A, 3, 50, tx_e, en_e);
    checks++;
    if (tx_v !== tx_e || en_v !== en_e) begin
      errors++; $display("FAIL overrun_line got=%h/%h want=%h/%h", tx_v, en_v, tx_e, en_e);
    end
    rd(2'd2, v); checks++;
    if (v !== 32'd6) begin errors++; $display("FAIL overrun_flag got=%h want=6", v); end
    rd(2'd0, v); checks++;
    if (v !== 32'h5A) begin errors++; $display("FAIL overrun_txdata got=%h want=5a", v); end
    wr(2'd2, 32'd6);
    rd(2'd2, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL overrun_clear got=%h want=0", v); end
  endtask

  task automatic test_disabled;
    wr(2'd1, 32'd0);
    wr(2'd0, 32'hFF);
    capture(10, tx_v, en_v);
    checks++;
    if (en_v !== 128'd0 || tx_v !== '1) begin errors++; $display("FAIL disabled_line en=%h tx=%h want=0/all1", en_v, tx_v); end
    rd(2'd2, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL disabled_status got=%h want=0", v); end
    rd(2'd0, v); checks++;
    if (v !== 32'h5A) begin errors++; $display("FAIL disabled_txdata got=%h want=5a", v); end
  endtask

  task automatic test_div;
    wr(2'd1, 32'd3);
    wr(2'd3, 32'd0);
    wr(2'd0, 32'h00);
    fork
      capture(14, tx_v, en_v);
      wr(2'd3, 32'd9);
    join
    expect_frame(8'h00, 0, 14, tx_e, en_e);
    checks++;
    if (tx_v !== tx_e || en_v !== en_e) begin
      errors++; $display("FAIL div0_frame got=%h/%h want=%h/%h", tx_v, en_v, tx_e, en_e);
    end
    rd(2'd3, v); checks++;
    if (v !== 32'd9) begin errors++; $display("FAIL div_readback got=%0d want=9", v); end
    wr(2'd2, 32'd2);
    wr(2'd0, 32'hC3);
    capture(122, tx_v, en_v);
    expect_frame(8'hC3, 9, 122, tx_e, en_e);
    checks++;
    if (tx_v !== tx_e || en_v !== en_e) begin
      errors++; $display("FAIL div9_frame got=%h/%h want=%h/%h", tx_v, en_v, tx_e, en_e);
    end
    wr(2'd2, 32'd6);
  endtask

  task automatic test_back_to_back;
    wr(2'd3, 32'd3);
    wr(2'd0, 32'h11);
    repeat (46) @(negedge clk);
    wr(2'd0, 32'h22);
    rd(2'd2, v); checks++;
    if (v !== 32'd6 || trans_en !== 1'b0) begin
      errors++; $display("FAIL trail_overrun status=%h en=%b want=6/0", v, trans_en);
    end
    wr(2'd2, 32'd6);
    wr(2'd0, 32'h33);
    rd(2'd0, v); checks++;
    if (v !== 32'h33 || trans_en !== 1'b1) begin
      errors++; $display("FAIL restart txdata=%h en=%b want=33/1", v, trans_en);
    end
    repeat (50) @(negedge clk);
    wr(2'd2, 32'd6);
  endtask

  task automatic test_abort;
    wr(2'd0, 32'hA5);
    repeat (12) @(negedge clk);
    wr(2'd1, 32'd0);
    rd(2'd2, v); checks++;
    if ({trans_en, tx_serial} !== 2'b01 || v !== 32'd0) begin
      errors++; $display("FAIL abort en=%b tx=%b status=%h want=0/1/0", trans_en, tx_serial, v);
    end
    repeat (60) @(negedge clk);
    rd(2'd2, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL abort_no_done got=%h want=0", v); end
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hA5);
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    #1;
    rd(2'd3, v); checks++;
    if ({trans_en, tx_serial, irq} !== 3'b010 || v !== 32'd434) begin
      errors++; $display("FAIL async_reset pins=%b div=%0d want=010/434", {trans_en, tx_serial, irq}, v);
    end
    rd(2'd1, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL async_reset_ctrl got=%h want=0", v); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_overrun;
    test_disabled;
    test_div;
    test_back_to_back;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
